// File: rtl/d_latch_stim_chk.sv
// Stimulus generator and checker for a D-latch under test: drives LFSR vectors on d/en,
// tracks the value an ideal latch should hold, and counts pass/fail/skip per vector.
module d_latch_stim_chk #(
  parameter int unsigned NUM_VECTORS = 16,
  parameter int unsigned HOLD        = 4,
  parameter logic [7:0]  SEED        = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       out_i,
  output logic       d_o,
  output logic       en_o,
  output logic       busy,
  output logic       done,
  output logic       all_pass,
  output logic [7:0] pass_cnt,
  output logic [7:0] fail_cnt,
  output logic [7:0] skip_cnt,
  output logic       err_pulse,
  output logic [7:0] err_idx,
  output logic       err_exp,
  output logic       err_got
);

  // state  | meaning
  // IDLE   | waiting for start, outputs at reset values
  // DRIVE  | current vector on d_o/en_o, held for HOLD cycles
  // SAMPLE | compare out_i against the reference model for one cycle
  // DONE   | run finished, results held until restart or reset
  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_SAMPLE, S_DONE} state_t;

  localparam logic [7:0] LAST_IDX  = 8'(NUM_VECTORS - 1);
  localparam logic [7:0] HOLD_LAST = 8'(HOLD - 1);

  state_t     state_q;
  logic [7:0] lfsr_q;
  logic [7:0] lfsr_d;
  logic [7:0] idx_q;
  logic [7:0] hold_q;
  logic [7:0] pass_q;
  logic [7:0] fail_q;
  logic [7:0] skip_q;
  logic [7:0] err_idx_q;
  logic       model_q;
  logic       model_valid_q;
  logic       busy_q;
  logic       done_q;
  logic       err_pulse_q;
  logic       err_exp_q;
  logic       err_got_q;

  assign lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      lfsr_q        <= 8'd0;
      idx_q         <= 8'd0;
      hold_q        <= 8'd0;
      pass_q        <= 8'd0;
      fail_q        <= 8'd0;
      skip_q        <= 8'd0;
      err_idx_q     <= 8'd0;
      model_q       <= 1'b0;
      model_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_pulse_q   <= 1'b0;
      err_exp_q     <= 1'b0;
      err_got_q     <= 1'b0;
    end else begin
      err_pulse_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_q   <= S_DRIVE;
            lfsr_q    <= SEED;
            idx_q     <= 8'd0;
            hold_q    <= 8'd0;
            pass_q    <= 8'd0;
            fail_q    <= 8'd0;
            skip_q    <= 8'd0;
            err_idx_q <= 8'd0;
            err_exp_q <= 1'b0;
            err_got_q <= 1'b0;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
            // model follows the first vector immediately if it enables the latch
            model_valid_q <= SEED[1];
            model_q       <= SEED[1] & SEED[0];
          end
        end
        S_DRIVE: begin
          if (hold_q == HOLD_LAST) begin
            state_q <= S_SAMPLE;
            hold_q  <= 8'd0;
          end else begin
            hold_q <= hold_q + 8'd1;
          end
        end
        S_SAMPLE: begin
          if (!model_valid_q) begin
            skip_q <= sat_inc(skip_q);
          end else if (out_i == model_q) begin
            pass_q <= sat_inc(pass_q);
          end else begin
            fail_q      <= sat_inc(fail_q);
            err_pulse_q <= 1'b1;
            err_idx_q   <= idx_q;
            err_exp_q   <= model_q;
            err_got_q   <= out_i;
          end
          lfsr_q <= lfsr_d;
          idx_q  <= idx_q + 8'd1;
          if (idx_q == LAST_IDX) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            state_q <= S_DRIVE;
            if (lfsr_d[1]) begin
              model_q       <= lfsr_d[0];
              model_valid_q <= 1'b1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign d_o       = lfsr_q[0];
  assign en_o      = lfsr_q[1];
  assign busy      = busy_q;
  assign done      = done_q;
  assign all_pass  = done_q & (fail_q == 8'd0);
  assign pass_cnt  = pass_q;
  assign fail_cnt  = fail_q;
  assign skip_cnt  = skip_q;
  assign err_pulse = err_pulse_q;
  assign err_idx   = err_idx_q;
  assign err_exp   = err_exp_q;
  assign err_got   = err_got_q;

endmodule

// File: tb/tb_d_latch_stim_chk.sv
// Scoreboard bench: a vector-level model queues expected vectors, mismatch events and run
// summaries at each start; monitors pop and compare as the DUT presents them.
module tb_d_latch_stim_chk;

  localparam int          NV = 16;
  localparam int          HD = 4;
  localparam logic [7:0]  SD = 8'hA5;

  logic       clk = 1'b0;
  logic       rst, start, out_i;
  logic       d_o, en_o, busy, done, all_pass, err_pulse, err_exp, err_got;
  logic [7:0] pass_cnt, fail_cnt, skip_cnt, err_idx;

  logic       start_s;
  logic       d_s, en_s, busy_s, done_s, all_pass_s, err_pulse_s, err_exp_s, err_got_s;
  logic [7:0] pass_s, fail_s, skip_s, err_idx_s;

  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   cur_sc = 0;
  int   out_mode = 0;
  int   done_events = 0;
  logic done_prev = 1'b0;
  logic lat = 1'b0;

  typedef struct {int cyc; bit d; bit en; bit first; int v;} vec_t;
  typedef struct {int cyc; int idx; bit e_v; bit g_v;} err_t;
  typedef struct {int cyc; int p; int f; int s; int eidx; bit e_v; bit g_v;} sum_t;

  vec_t vec_q[$];
  err_t err_q[$];
  sum_t sum_q[$];
  sum_t last_sum;

  d_latch_stim_chk #(.NUM_VECTORS(NV), .HOLD(HD), .SEED(SD)) dut (
    .clk(clk), .rst(rst), .start(start), .out_i(out_i),
    .d_o(d_o), .en_o(en_o), .busy(busy), .done(done), .all_pass(all_pass),
    .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .skip_cnt(skip_cnt),
    .err_pulse(err_pulse), .err_idx(err_idx), .err_exp(err_exp), .err_got(err_got)
  );

  d_latch_stim_chk #(.NUM_VECTORS(1), .HOLD(1), .SEED(SD)) dut_small (
    .clk(clk), .rst(rst), .start(start_s), .out_i(1'b0),
    .d_o(d_s), .en_o(en_s), .busy(busy_s), .done(done_s), .all_pass(all_pass_s),
    .pass_cnt(pass_s), .fail_cnt(fail_s), .skip_cnt(skip_s),
    .err_pulse(err_pulse_s), .err_idx(err_idx_s), .err_exp(err_exp_s), .err_got(err_got_s)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // latch-under-test stand-in: transparent while en_o, settles well before any sample
  always @(negedge clk) if (en_o) lat <= d_o;
  assign out_i = (out_mode == 0) ? lat : (out_mode == 1) ? 1'b0 : (out_mode == 2) ? 1'b1 : ~lat;

  task automatic check(input string name, input longint got, input longint expv);
    n_checks++;
    if (got != expv) begin
      n_errors++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", name, cyc, got, expv);
    end
  endtask

  function automatic logic [7:0] next_lfsr(input logic [7:0] l);
    return {l[6:0], ^(l & 8'hB8)};
  endfunction

  // Vector-level reference: latch value is the d of the latest enabled vector of the run.
  task automatic issue_run(input int mode, input int sc);
    logic [7:0] l = SD;
    bit mv = 0, m = 0, g;
    sum_t su;
    su = '{cyc: (sc - 1) + NV * (HD + 1) + 1, p: 0, f: 0, s: 0, eidx: 0, e_v: 0, g_v: 0};
    for (int v = 0; v < NV; v++) begin
      if (l[1]) begin m = l[0]; mv = 1; end
      vec_q.push_back('{cyc: sc + v * (HD + 1), d: l[0], en: l[1], first: 1, v: v});
      vec_q.push_back('{cyc: sc + v * (HD + 1) + HD, d: l[0], en: l[1], first: 0, v: v});
      if (!mv) su.s++;
      else begin
        g = (mode == 0) ? m : (mode == 1) ? 1'b0 : (mode == 2) ? 1'b1 : !m;
        if (g == m) su.p++;
        else begin
          su.f++;
          su.eidx = v; su.e_v = m; su.g_v = g;
          err_q.push_back('{cyc: sc + v * (HD + 1) + HD + 1, idx: v, e_v: m, g_v: g});
        end
      end
      l = next_lfsr(l);
    end
    sum_q.push_back(su);
  endtask

  always @(negedge clk) begin : mon_vec
    vec_t e;
    while (vec_q.size() > 0 && vec_q[0].cyc < cyc) begin
      e = vec_q.pop_front();
      check("vec_missed", 0, 1);
    end
    if (vec_q.size() > 0 && vec_q[0].cyc == cyc) begin
      e = vec_q.pop_front();
      check(e.first ? "vec_d_drive" : "vec_d_sample", d_o, e.d);
      check(e.first ? "vec_en_drive" : "vec_en_sample", en_o, e.en);
      check("vec_busy", busy, 1);
      check("vec_done", done, 0);
      if (e.first && e.v == 0)
        check("cnt_clear_on_start", {pass_cnt, fail_cnt, skip_cnt}, 0);
    end
  end

  always @(negedge clk) begin : mon_err
    err_t e;
    if (err_pulse) begin
      if (err_q.size() == 0) check("err_unexpected", 1, 0);
      else begin
        e = err_q.pop_front();
        check("err_cycle", cyc, e.cyc);
        check("err_idx", err_idx, e.idx);
        check("err_exp", err_exp, e.e_v);
        check("err_got", err_got, e.g_v);
      end
    end
  end

  always @(negedge clk) begin : mon_done
    sum_t e;
    done_prev <= done;
    if (done && !done_prev) begin
      done_events <= done_events + 1;
      if (sum_q.size() == 0) check("done_unexpected", 1, 0);
      else begin
        e = sum_q.pop_front();
        last_sum <= e;
        check("done_cycle", cyc, e.cyc);
        check("pass_cnt", pass_cnt, e.p);
        check("fail_cnt", fail_cnt, e.f);
        check("skip_cnt", skip_cnt, e.s);
        check("cnt_sum", pass_cnt + fail_cnt + skip_cnt, NV);
        check("all_pass", all_pass, e.f == 0);
        check("busy_at_done", busy, 0);
        check("done_err_idx", err_idx, e.eidx);
        check("done_err_exp", err_exp, e.e_v);
        check("done_err_got", err_got, e.g_v);
      end
    end
  end

  task automatic flush();
    vec_q.delete(); err_q.delete(); sum_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk); #1;
    flush();
    rst = 1'b1; start = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0; start = 1'b0;
    @(negedge clk);
    check("reset_outputs", {d_o, en_o, busy, done, all_pass, pass_cnt, fail_cnt, skip_cnt,
                            err_pulse, err_idx, err_exp, err_got}, 0);
    check("reset_small", {d_s, en_s, busy_s, done_s, all_pass_s, pass_s, fail_s, skip_s}, 0);
  endtask

  task automatic do_start(input int mode);
    @(posedge clk); #1;
    out_mode = mode;
    start = 1'b1;
    cur_sc = cyc + 1;
    issue_run(mode, cur_sc);
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit pulses);
    int seen = done_events;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (done_events != seen) begin
        start = 1'b0;
        return;
      end
      start = pulses && cyc >= cur_sc && cyc <= cur_sc + NV * (HD + 1) - 2
              && $urandom_range(0, 3) == 0;
    end
    start = 1'b0;
    check("done_timeout", 0, 1);
    flush();
  endtask

  task automatic dwell();
    repeat ($urandom_range(1, 5)) @(posedge clk);
    #1;
    check("hold_counts", {pass_cnt, fail_cnt, skip_cnt},
          {8'(last_sum.p), 8'(last_sum.f), 8'(last_sum.s)});
    check("hold_err", {err_idx, err_exp, err_got},
          {8'(last_sum.eidx), last_sum.e_v, last_sum.g_v});
    check("hold_done", {busy, done}, 2'b01);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; start_s = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    do_reset();

    do_start(0); wait_done(200, 0); dwell();
    do_start(1); wait_done(200, 0); dwell();

    for (int r = 0; r < 6; r++) begin
      if ($urandom_range(0, 2) == 0) do_reset();
      do_start(int'($urandom_range(0, 3)));
      wait_done(200, 1);
      dwell();
    end

    do_start(0);
    while (cyc < cur_sc + 29) @(posedge clk);
    do_reset();
    do_start(0); wait_done(200, 0); dwell();
    do_reset();

    @(posedge clk); #1 start_s = 1'b1;
    cur_sc = cyc + 1;
    @(posedge clk); #1 start_s = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("small_busy", busy_s, k < 2);
      check("small_done", done_s, k == 2);
      if (k == 0) check("small_vec", {d_s, en_s}, {SD[0], SD[1]});
    end
    check("small_cycle", cyc - (cur_sc - 1), 3);
    check("small_counts", {pass_s, fail_s, skip_s}, {8'd0, 8'd0, 8'd1});
    check("small_all_pass", all_pass_s, 1);

    check("vec_q_empty", vec_q.size(), 0);
    check("err_q_empty", err_q.size(), 0);
    check("sum_q_empty", sum_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
